wform_capture: RTL and testbench
================================

Name: wform_capture

Overview:
- Serial waveform recorder: samples a 1-bit waveform once per clk and assembles it LSB-first into 8-bit bytes.
- Stores DEPTH consecutive bytes in an internal register file, which is readable asynchronously afterwards.
- Receive-side counterpart of the waveform generator, which serializes a byte memory LSB-first through a 3-bit bit counter and an address counter.
- Used to capture generator output and check it against the programmed pattern.

Parameters:
- DEPTH, 8, number of bytes captured per run (power of two, 2..16)
- ADDR_W, 3, address width, equal to log2(DEPTH)
- SYNC_BYTE, 8'hCC, pattern hunted for when SYNC_DETECT_EN is defined

Ports:
- clk  input  1  clock; all state changes on its rising edge
- clear  input  1  synchronous active-high reset
- wform  input  1  serial waveform, sampled every rising clk edge
- start  input  1  begin a capture run; honoured only in IDLE or DONE
- rd_addr  input  ADDR_W  read address into the capture memory
- rd_data  output  8  combinational read of mem[rd_addr]
- byte_out  output  8  most recently completed byte
- byte_valid  output  1  one-cycle pulse when byte_out updates
- busy  output  1  high in HUNT or CAPTURE
- done  output  1  high in DONE, held until start or clear

Behaviour:
- Reset: clear=1 at an edge forces the following, overriding everything including a mid-capture run:
  - state=IDLE; bit_cnt=0; byte_addr=0; shift=0
  - byte_out=0; byte_valid=0; busy=0; done=0
  - all DEPTH mem entries=8'h00
- States: IDLE, CAPTURE, DONE (plus HUNT when SYNC_DETECT_EN is defined).
- IDLE/DONE: start=1 at edge E moves to CAPTURE and clears bit_cnt, byte_addr and done. wform is not sampled at E.
- CAPTURE sampling:
  - Each edge: shift <= {wform, shift[7:1]}, so the first sampled bit ends up in bit 0 (LSB-first); bit_cnt increments mod 8.
  - First data bit is sampled at edge E+1.
- Byte completion (edge where bit_cnt==7):
  - mem[byte_addr] <= {wform, shift[7:1]}; byte_out gets the same value; byte_valid=1 for the next cycle.
  - byte_addr increments.
  - If byte_addr==DEPTH-1: state->DONE, done=1, busy=0.
- Latency: byte k (0-based) is written at edge E+8k+8. Run complete at edge E+8*DEPTH.
- start while busy: ignored, with no restart and no corruption.
- start in DONE: new run begins; old mem contents persist until overwritten byte by byte.
- byte_addr wrap: never wraps within a run; DONE stops at DEPTH bytes.
- Read port:
  - rd_data is purely combinational on rd_addr.
  - Reading the address being written in the same cycle returns the old value until the edge.
- Outputs are registered except rd_data.

Optional Feature:
- Macro: SYNC_DETECT_EN.
- Defined: start moves to HUNT (busy=1) instead of CAPTURE.
  - HUNT shifts wform LSB-first every edge; a saturating counter tracks bits seen since entry.
  - Once at least 8 bits have been seen and the shifted value equals SYNC_BYTE, the FSM moves to CAPTURE with bit_cnt=0.
  - The next sampled bit is bit 0 of mem[0]. The sync byte itself is not stored and no byte_valid is raised for it.
  - clear or completion behave as above; HUNT has no timeout.
- Not defined: HUNT state and sync logic are absent; start goes directly to CAPTURE.

Test Plan:
- Reset: drive clear=1 for 1 cycle mid-capture (after 13 bits) -> next cycle busy=0, done=0, byte_valid=0, byte_out=0, rd_data=0 for all rd_addr 0..7.
- Basic capture: start pulse, then 64 bits of alternating CC,AA sent LSB-first (0,0,1,1,0,0,1,1 then 0,1,0,1,0,1,0,1 ...) -> byte_valid pulses every 8 cycles, byte_out=CC,AA,... -> done=1 exactly 64 edges after start -> mem[even]=CC, mem[odd]=AA.
- Bit order: capture byte stream 01,80,FF,00,5A,A5,3C,C3 -> rd_addr 0..7 returns those values exactly.
- start while busy: assert start at bit 20 -> ignored; final contents identical to an unperturbed run; done at edge E+64.
- Restart from DONE: second run of constant wform=1 -> mem[0..7]=FF. Read mem[7]=old value until its write edge, then FF.
- SYNC_DETECT_EN build: 5 junk bits, then CC, then AA,CC,... -> mem[0]=AA, mem[1]=CC. A run whose wform carries no CC keeps busy=1 and done=0 indefinitely.

Source files
------------

// File: rtl/wform_capture.sv
// wform_capture: serial waveform recorder.
// Samples a 1-bit waveform once per clk, assembles it LSB-first into bytes and
// stores DEPTH consecutive bytes in a register file with a combinational read port.
// Optional build macro SYNC_DETECT_EN: hunt for SYNC_BYTE before capturing.
module wform_capture #(
   parameter int         DEPTH     = 8,
   parameter int         ADDR_W    = 3,
   parameter logic [7:0] SYNC_BYTE = 8'hCC
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              wform,
   input  logic              start,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
`ifdef SYNC_DETECT_EN
      , ST_HUNT  = 2'd3
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        byte_out_q, byte_out_d;
   logic              byte_valid_q, byte_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wr_en_s;
   logic [7:0]        shifted_s;
   logic [7:0]        mem_q [DEPTH];
`ifdef SYNC_DETECT_EN
   logic [3:0]        hunt_cnt_q, hunt_cnt_d;
`endif

   // Next-state and output decode for the capture FSM.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_addr_d  = byte_addr_q;
      shift_d      = shift_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      busy_d       = busy_q;
      done_d       = done_q;
      wr_en_s      = 1'b0;
      shifted_s    = {wform, shift_q[7:1]};
`ifdef SYNC_DETECT_EN
      hunt_cnt_d   = hunt_cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // wform is not sampled on the start edge
               bit_cnt_d   = 3'd0;
               byte_addr_d = '0;
               done_d      = 1'b0;
               busy_d      = 1'b1;
`ifdef SYNC_DETECT_EN
               state_d     = ST_HUNT;
               hunt_cnt_d  = 4'd0;
`else
               state_d     = ST_CAPTURE;
`endif
            end else begin
               state_d = state_q;
            end
         end
`ifdef SYNC_DETECT_EN
         ST_HUNT: begin
            shift_d = shifted_s;
            if (hunt_cnt_q != 4'd8) begin
               hunt_cnt_d = hunt_cnt_q + 4'd1;
            end else begin
               hunt_cnt_d = hunt_cnt_q;
            end
            // hunt_cnt_q >= 7 means this edge's bit makes at least 8 seen
            if ((hunt_cnt_q >= 4'd7) && (shifted_s == SYNC_BYTE)) begin
               state_d   = ST_CAPTURE;
               bit_cnt_d = 3'd0;
            end else begin
               state_d = ST_HUNT;
            end
         end
`endif
         ST_CAPTURE: begin
            shift_d   = shifted_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               wr_en_s      = 1'b1;
               byte_out_d   = shifted_s;
               byte_valid_d = 1'b1;
               byte_addr_d  = byte_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               if (byte_addr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // Control and output registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         byte_addr_q  <= '0;
         shift_q      <= 8'h00;
         byte_out_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef SYNC_DETECT_EN
         hunt_cnt_q   <= 4'd0;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_addr_q  <= byte_addr_d;
         shift_q      <= shift_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef SYNC_DETECT_EN
         hunt_cnt_q   <= hunt_cnt_d;
`endif
      end
   end

   // Capture memory: zeroed on clear, one byte written per completed byte.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (wr_en_s) begin
         mem_q[byte_addr_q] <= shifted_s;
      end else begin
         mem_q[byte_addr_q] <= mem_q[byte_addr_q];
      end
   end

   assign rd_data    = mem_q[rd_addr];
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_wform_capture.sv
// Self-checking bench for wform_capture (default build): directed scenarios
// plus random traffic, checked every cycle against a run-level reference model.
module tb_wform_capture;

   logic       clk;
   logic       clear;
   logic       wform;
   logic       start;
   logic [2:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   wform_capture #(.DEPTH(8), .ADDR_W(3), .SYNC_BYTE(8'hCC)) dut (
      .clk        (clk),
      .clear      (clear),
      .wform      (wform),
      .start      (start),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is "active" for 8*DEPTH sampled bits after start.
   bit [7:0] m_mem [8];
   bit [7:0] m_bout;
   bit [7:0] m_acc;
   bit       m_bv;
   bit       m_busy;
   bit       m_done;
   int       m_t;

   task automatic model_step(input bit c, input bit s, input bit w);
      m_bv = 1'b0;
      if (c) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
         m_bout = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_acc = 8'h00;
      end else if (!m_busy) begin
         if (s) begin
            m_busy = 1'b1; m_done = 1'b0; m_t = 0; m_acc = 8'h00;
         end
      end else begin
         m_acc[m_t % 8] = w;
         m_t++;
         if (m_t % 8 == 0) begin
            m_mem[m_t / 8 - 1] = m_acc;
            m_bout = m_acc;
            m_bv   = 1'b1;
            m_acc  = 8'h00;
            if (m_t == 64) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   endtask

   // Advance the model on each edge and compare all outputs just after it.
   always @(posedge clk) begin
      model_step(clear, start, wform);
      #1;
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("byte_valid", {31'd0, byte_valid}, {31'd0, m_bv});
      chk("byte_out", {24'd0, byte_out}, {24'd0, m_bout});
      chk("rd_data", {24'd0, rd_data}, {24'd0, m_mem[rd_addr]});
   end

   task automatic drive(input bit c, input bit s, input bit w, input logic [2:0] a);
      clear = c; start = s; wform = w; rd_addr = a;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, v[i], 3'($urandom_range(0, 7)));
   endtask

   task automatic read_chk(input logic [2:0] a, input logic [7:0] exp, input string name);
      clear = 1'b0; start = 1'b0; rd_addr = a;
      #1;
      chk(name, {24'd0, rd_data}, {24'd0, exp});
      @(negedge clk);
   endtask

   logic [7:0] order_bytes [8];
   logic [7:0] rb [8];
   logic [7:0] bit_src;

   initial begin
      clear = 1'b1; start = 1'b0; wform = 1'b0; rd_addr = 3'd0;
      drive(1'b1, 1'b0, 1'b0, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 3'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_byte_out", {24'd0, byte_out}, 32'd0);

      // Basic capture: CC,AA alternating, done exactly 64 edges after start.
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 64; i++) begin
         bit_src = ((i / 8) % 2 == 0) ? 8'hCC : 8'hAA;
         drive(1'b0, 1'b0, bit_src[i % 8], 3'($urandom_range(0, 7)));
         if (i == 6) chk("first_valid_early", {31'd0, byte_valid}, 32'd0);
         if (i == 7) begin
            chk("first_valid", {31'd0, byte_valid}, 32'd1);
            chk("first_byte", {24'd0, byte_out}, 32'hCC);
         end
         if (i == 15) chk("second_byte", {24'd0, byte_out}, 32'hAA);
         if (i == 62) chk("done_edge63", {31'd0, done}, 32'd0);
         if (i == 63) chk("done_edge64", {31'd0, done}, 32'd1);
      end
      for (int a = 0; a < 8; a++) read_chk(3'(a), (a % 2 == 0) ? 8'hCC : 8'hAA, "basic_mem");

      // Bit order.
      order_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 8; k++) send_byte(order_bytes[k]);
      for (int a = 0; a < 8; a++) read_chk(3'(a), order_bytes[a], "order_mem");

      // start while busy (at bit 20) is ignored; last byte pinned to 5A.
      for (int k = 0; k < 7; k++) rb[k] = 8'($urandom);
      rb[7] = 8'h5A;
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 64; i++) begin
         bit_src = rb[i / 8];
         drive(1'b0, (i == 20) || (i == 41), bit_src[i % 8], 3'($urandom_range(0, 7)));
         if (i == 62) chk("busy_start_done63", {31'd0, done}, 32'd0);
         if (i == 63) chk("busy_start_done64", {31'd0, done}, 32'd1);
      end
      for (int a = 0; a < 8; a++) read_chk(3'(a), rb[a], "busy_start_mem");

      // Restart from DONE with constant 1; mem[7] holds 5A until its write edge.
      drive(1'b0, 1'b1, 1'b0, 3'd7);
      for (int i = 0; i < 63; i++) drive(1'b0, 1'b0, 1'b1, 3'd7);
      #1;
      chk("mem7_before_write", {24'd0, rd_data}, 32'h5A);
      @(negedge clk);
      chk("mem7_after_write", {24'd0, rd_data}, 32'hFF);
      for (int a = 0; a < 8; a++) read_chk(3'(a), 8'hFF, "restart_mem");

      // Clear mid-capture after 13 bits.
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 13; i++) drive(1'b0, 1'b0, 1'($urandom), 3'd0);
      drive(1'b1, 1'b0, 1'b1, 3'd0);
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_done", {31'd0, done}, 32'd0);
      chk("clr_valid", {31'd0, byte_valid}, 32'd0);
      chk("clr_byte_out", {24'd0, byte_out}, 32'd0);
      for (int a = 0; a < 8; a++) read_chk(3'(a), 8'h00, "clr_mem");

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0),
               1'($urandom), 3'($urandom_range(0, 7)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
